// File: rtl/simplebus_pkg.sv
// Shared SimpleBus field widths, request/response structs and arbiter state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simplebus_pkg;

  localparam int ADDR_W  = 32;
  localparam int SIZE_W  = 3;
  localparam int CMD_W   = 4;
  localparam int WMASK_W = 8;
  localparam int DATA_W  = 64;
  localparam int USER_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [SIZE_W-1:0]  size;
    logic [CMD_W-1:0]   cmd;
    logic [WMASK_W-1:0] wmask;
    logic [DATA_W-1:0]  wdata;
    logic [USER_W-1:0]  user;
  } sb_req_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] rdata;
    logic [USER_W-1:0] user;
  } sb_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/simplebus_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port not granted last.
// Latency: purely combinational.
// Backpressure: grant is forced to zero while en is low.
module simplebus_rr_arb (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Pick the winning index, then expand it to one-hot when a grant is allowed.
  always_comb begin
    grant_idx = 1'b0;
    grant     = 2'b00;
    case (valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    if (en && (valid != 2'b00)) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/simplebus_arbiter.sv
// Two-port SimpleBus arbiter with one outstanding transaction toward a shared slave.
// Latency: out_req_valid one cycle after the accepting input handshake; responses routed combinationally.
// Backpressure: request held stable until out_req_ready; out_resp_ready mirrors the owner's resp_ready.
module simplebus_arbiter
  import simplebus_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int FIRST_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in0_req_valid,
  output logic               in0_req_ready,
  input  logic [ADDR_W-1:0]  in0_req_bits_addr,
  input  logic [SIZE_W-1:0]  in0_req_bits_size,
  input  logic [CMD_W-1:0]   in0_req_bits_cmd,
  input  logic [WMASK_W-1:0] in0_req_bits_wmask,
  input  logic [DATA_W-1:0]  in0_req_bits_wdata,
  input  logic [USER_W-1:0]  in0_req_bits_user,
  output logic               in0_resp_valid,
  input  logic               in0_resp_ready,
  output logic [CMD_W-1:0]   in0_resp_bits_cmd,
  output logic [DATA_W-1:0]  in0_resp_bits_rdata,
  output logic [USER_W-1:0]  in0_resp_bits_user,
  input  logic               in1_req_valid,
  output logic               in1_req_ready,
  input  logic [ADDR_W-1:0]  in1_req_bits_addr,
  input  logic [SIZE_W-1:0]  in1_req_bits_size,
  input  logic [CMD_W-1:0]   in1_req_bits_cmd,
  input  logic [WMASK_W-1:0] in1_req_bits_wmask,
  input  logic [DATA_W-1:0]  in1_req_bits_wdata,
  input  logic [USER_W-1:0]  in1_req_bits_user,
  output logic               in1_resp_valid,
  input  logic               in1_resp_ready,
  output logic [CMD_W-1:0]   in1_resp_bits_cmd,
  output logic [DATA_W-1:0]  in1_resp_bits_rdata,
  output logic [USER_W-1:0]  in1_resp_bits_user,
  output logic               out_req_valid,
  input  logic               out_req_ready,
  output logic [ADDR_W-1:0]  out_req_bits_addr,
  output logic [SIZE_W-1:0]  out_req_bits_size,
  output logic [CMD_W-1:0]   out_req_bits_cmd,
  output logic [WMASK_W-1:0] out_req_bits_wmask,
  output logic [DATA_W-1:0]  out_req_bits_wdata,
  output logic [USER_W-1:0]  out_req_bits_user,
  input  logic               out_resp_valid,
  output logic               out_resp_ready,
  input  logic [CMD_W-1:0]   out_resp_bits_cmd,
  input  logic [DATA_W-1:0]  out_resp_bits_rdata,
  input  logic [USER_W-1:0]  out_resp_bits_user,
  output logic               busy
);

  arb_state_t        state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  sb_req_t           req_q;
  sb_req_t           in0_req, in1_req, out_req;
  sb_resp_t          slv_resp, resp0, resp1;
  logic [NUM_IN-1:0] req_valid;
  logic [1:0]        grant;
  logic              grant_idx;
  logic              idle_act, req_act, resp_act;
  logic              owner_resp_ready;

  assign in0_req   = {in0_req_bits_addr, in0_req_bits_size, in0_req_bits_cmd,
                      in0_req_bits_wmask, in0_req_bits_wdata, in0_req_bits_user};
  assign in1_req   = {in1_req_bits_addr, in1_req_bits_size, in1_req_bits_cmd,
                      in1_req_bits_wmask, in1_req_bits_wdata, in1_req_bits_user};
  assign slv_resp  = {out_resp_bits_cmd, out_resp_bits_rdata, out_resp_bits_user};
  assign req_valid = {in1_req_valid, in0_req_valid};

  // Reset forces every output quiet in the same cycle, so phases are qualified by !rst.
  assign idle_act = (state_q == IDLE) && !rst;
  assign req_act  = (state_q == REQ)  && !rst;
  assign resp_act = (state_q == RESP) && !rst;
  assign owner_resp_ready = owner_q ? in1_resp_ready : in0_resp_ready;

  simplebus_rr_arb u_rr_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .en         (idle_act),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // State, ownership and captured request; a grant latches the winner's fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= (FIRST_PRIO == 0);
      owner_q      <= 1'b0;
      req_q        <= '0;
    end else begin
      state_q <= state_d;
      if (grant != 2'b00) begin
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
        req_q        <= grant_idx ? in1_req : in0_req;
      end
    end
  end

  // Next state plus handshake/routing outputs; non-owner and off-phase outputs stay 0.
  always_comb begin
    state_d        = state_q;
    in0_req_ready  = grant[0];
    in1_req_ready  = grant[1];
    busy           = (state_q != IDLE) && !rst;
    out_req_valid  = req_act;
    out_req        = '0;
    out_resp_ready = 1'b0;
    in0_resp_valid = 1'b0;
    in1_resp_valid = 1'b0;
    resp0          = '0;
    resp1          = '0;

    if (req_act) begin
      out_req = req_q;
    end
    if (resp_act) begin
      out_resp_ready = owner_resp_ready;
      if (owner_q) begin
        in1_resp_valid = out_resp_valid;
        resp1          = slv_resp;
      end else begin
        in0_resp_valid = out_resp_valid;
        resp0          = slv_resp;
      end
    end

    case (state_q)
      IDLE:    if (grant != 2'b00) state_d = REQ;
      REQ:     if (out_req_ready) state_d = RESP;
      RESP:    if (out_resp_valid && owner_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_req_bits_addr   = out_req.addr;
  assign out_req_bits_size   = out_req.size;
  assign out_req_bits_cmd    = out_req.cmd;
  assign out_req_bits_wmask  = out_req.wmask;
  assign out_req_bits_wdata  = out_req.wdata;
  assign out_req_bits_user   = out_req.user;
  assign in0_resp_bits_cmd   = resp0.cmd;
  assign in0_resp_bits_rdata = resp0.rdata;
  assign in0_resp_bits_user  = resp0.user;
  assign in1_resp_bits_cmd   = resp1.cmd;
  assign in1_resp_bits_rdata = resp1.rdata;
  assign in1_resp_bits_user  = resp1.user;

endmodule

// File: tb/tb_simplebus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: randomized on both slave-side and requester-side ready signals.
module tb_simplebus_arbiter;
  import simplebus_pkg::*;

  localparam int FIRST_PRIO = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst;
  logic     v0, v1, rr0, rr1, o_rdy, o_rv;
  sb_req_t  r0, r1;
  sb_resp_t o_rsp;

  logic                rdy0, rdy1, rv0, rv1, ov, orr, busy;
  logic [CMD_W-1:0]    c0, c1, oc;
  logic [DATA_W-1:0]   d0, d1, od;
  logic [USER_W-1:0]   u0, u1, ou;
  logic [ADDR_W-1:0]   oa;
  logic [SIZE_W-1:0]   os;
  logic [WMASK_W-1:0]  ow;
  sb_resp_t            rb0, rb1;
  sb_req_t             ob;

  assign rb0 = {c0, d0, u0};
  assign rb1 = {c1, d1, u1};
  assign ob  = {oa, os, oc, ow, od, ou};

  int errors = 0;
  int checks = 0;

  // Transaction-level model: at most one pending transaction, forwarded or not.
  bit      m_busy, m_fwd, m_last, m_owner;
  sb_req_t m_req;
  logic [1:0] e_g;
  bit      e_req_ph, e_resp_ph;

  simplebus_arbiter #(.NUM_IN(2), .FIRST_PRIO(FIRST_PRIO)) dut (
    .clk(clk), .rst(rst),
    .in0_req_valid(v0), .in0_req_ready(rdy0),
    .in0_req_bits_addr(r0.addr), .in0_req_bits_size(r0.size), .in0_req_bits_cmd(r0.cmd),
    .in0_req_bits_wmask(r0.wmask), .in0_req_bits_wdata(r0.wdata), .in0_req_bits_user(r0.user),
    .in0_resp_valid(rv0), .in0_resp_ready(rr0),
    .in0_resp_bits_cmd(c0), .in0_resp_bits_rdata(d0), .in0_resp_bits_user(u0),
    .in1_req_valid(v1), .in1_req_ready(rdy1),
    .in1_req_bits_addr(r1.addr), .in1_req_bits_size(r1.size), .in1_req_bits_cmd(r1.cmd),
    .in1_req_bits_wmask(r1.wmask), .in1_req_bits_wdata(r1.wdata), .in1_req_bits_user(r1.user),
    .in1_resp_valid(rv1), .in1_resp_ready(rr1),
    .in1_resp_bits_cmd(c1), .in1_resp_bits_rdata(d1), .in1_resp_bits_user(u1),
    .out_req_valid(ov), .out_req_ready(o_rdy),
    .out_req_bits_addr(oa), .out_req_bits_size(os), .out_req_bits_cmd(oc),
    .out_req_bits_wmask(ow), .out_req_bits_wdata(od), .out_req_bits_user(ou),
    .out_resp_valid(o_rv), .out_resp_ready(orr),
    .out_resp_bits_cmd(o_rsp.cmd), .out_resp_bits_rdata(o_rsp.rdata), .out_resp_bits_user(o_rsp.user),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic sb_req_t rnd_req();
    sb_req_t r;
    r.addr  = $urandom;
    r.size  = 3'($urandom);
    r.cmd   = 4'($urandom);
    r.wmask = 8'($urandom);
    r.wdata = {$urandom, $urandom};
    r.user  = 16'($urandom);
    return r;
  endfunction

  function automatic sb_resp_t rnd_resp();
    sb_resp_t r;
    r.cmd   = 4'($urandom);
    r.rdata = {$urandom, $urandom};
    r.user  = 16'($urandom);
    return r;
  endfunction

  // Mid-cycle: derive expected outputs from the model and current inputs, compare all.
  task automatic settle();
    sb_req_t  exp_req;
    sb_resp_t exp0, exp1;
    #2;
    e_req_ph  = m_busy && !m_fwd && !rst;
    e_resp_ph = m_busy && m_fwd && !rst;
    e_g = 2'b00;
    if (!m_busy && !rst) begin
      if (v0 && v1) e_g = m_last ? 2'b01 : 2'b10;
      else          e_g = {v1, v0};
    end
    exp_req = e_req_ph ? m_req : '0;
    exp0    = (e_resp_ph && !m_owner) ? o_rsp : '0;
    exp1    = (e_resp_ph &&  m_owner) ? o_rsp : '0;
    chk("m_rdy0",  128'(rdy0), 128'(e_g[0]));
    chk("m_rdy1",  128'(rdy1), 128'(e_g[1]));
    chk("m_busy",  128'(busy), 128'(m_busy && !rst));
    chk("m_ov",    128'(ov),   128'(e_req_ph));
    chk("m_obits", 128'(ob),   128'(exp_req));
    chk("m_rv0",   128'(rv0),  128'(e_resp_ph && !m_owner && o_rv));
    chk("m_rv1",   128'(rv1),  128'(e_resp_ph &&  m_owner && o_rv));
    chk("m_rb0",   128'(rb0),  128'(exp0));
    chk("m_rb1",   128'(rb1),  128'(exp1));
    chk("m_orr",   128'(orr),  128'(e_resp_ph && (m_owner ? rr1 : rr0)));
  endtask

  // Clock edge: advance the model using the inputs that were just checked.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
      m_fwd  = 1'b0;
      m_last = (FIRST_PRIO == 0);
    end else if (e_g != 2'b00) begin
      m_busy  = 1'b1;
      m_fwd   = 1'b0;
      m_owner = e_g[1];
      m_last  = e_g[1];
      m_req   = e_g[1] ? r1 : r0;
    end else if (e_req_ph && o_rdy) begin
      m_fwd = 1'b1;
    end else if (e_resp_ph && o_rv && (m_owner ? rr1 : rr0)) begin
      m_busy = 1'b0;
      m_fwd  = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
  endtask

  int      gq[$];
  int      rq[$];
  int      n0, n1;
  sb_req_t cap;

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    o_rdy = 1'b0; o_rv = 1'b0; r0 = '0; r1 = '0; o_rsp = '0;
    m_busy = 1'b0; m_fwd = 1'b0; m_last = (FIRST_PRIO == 0); m_owner = 1'b0; m_req = '0;
    e_g = 2'b00; e_req_ph = 1'b0; e_resp_ph = 1'b0;

    // Reset with requests and a stray response present: everything must stay 0.
    v0 = 1'b1; v1 = 1'b1; r0 = rnd_req(); r1 = rnd_req(); o_rv = 1'b1; o_rsp = rnd_resp();
    settle();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rdy0", 128'(rdy0), 128'(0));
    chk("rst_rdy1", 128'(rdy1), 128'(0));
    advance();
    settle();
    chk("rst_ov",   128'(ov),   128'(0));
    chk("rst_orr",  128'(orr),  128'(0));
    advance();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; o_rv = 1'b0;

    // Single request from port 0.
    r0 = rnd_req(); r0.addr = 32'h8000_0000; r0.cmd = 4'h0; r0.user = 16'h0001; v0 = 1'b1;
    settle();
    chk("single_grant", 128'(rdy0), 128'(1));
    advance();
    v0 = 1'b0;
    settle();
    chk("single_latency", 128'(ov), 128'(1));
    chk("single_addr",    128'(oa), 128'(32'h8000_0000));
    chk("single_ouser",   128'(ou), 128'(16'h0001));
    advance();
    o_rdy = 1'b1;
    settle();
    advance();
    o_rdy = 1'b0; o_rv = 1'b1; rr0 = 1'b1;
    o_rsp.cmd = 4'h0; o_rsp.rdata = 64'hDEAD_BEEF; o_rsp.user = 16'h0001;
    settle();
    chk("single_rv0",   128'(rv0), 128'(1));
    chk("single_rdata", 128'(d0),  128'(64'hDEAD_BEEF));
    chk("single_user",  128'(u0),  128'(16'h0001));
    chk("single_rv1",   128'(rv1), 128'(0));
    advance();
    o_rv = 1'b0; rr0 = 1'b0;
    settle();
    chk("single_done", 128'(busy), 128'(0));
    advance();

    // Contention: both ports request continuously, three transactions each.
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1; o_rdy = 1'b1; o_rv = 1'b1; v0 = 1'b1; v1 = 1'b1;
    n0 = 0; n1 = 0;
    for (int cyc = 0; cyc < 200 && rq.size() < 6; cyc++) begin
      r0 = rnd_req(); r1 = rnd_req(); o_rsp = rnd_resp();
      settle();
      if (rdy0) begin gq.push_back(0); n0++; end
      if (rdy1) begin gq.push_back(1); n1++; end
      if (rv0) rq.push_back(0);
      if (rv1) rq.push_back(1);
      advance();
      v0 = (n0 < 3);
      v1 = (n1 < 3);
    end
    chk("cont_ngrant", 128'(gq.size()), 128'(6));
    chk("cont_nresp",  128'(rq.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) chk("cont_grant_order", 128'(gq[i]), 128'(i % 2));
      if (i < gq.size() && i < rq.size()) chk("cont_route", 128'(rq[i]), 128'(gq[i]));
    end
    o_rv = 1'b0; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0; o_rdy = 1'b0;

    // Backpressure on the slave request, then on the owner's response.
    r1 = rnd_req(); cap = r1; v1 = 1'b1;
    settle();
    chk("bp_grant", 128'(rdy1), 128'(1));
    advance();
    for (int i = 0; i < 5; i++) begin
      r1 = rnd_req(); v1 = 1'($urandom); v0 = 1'($urandom);
      settle();
      chk("bp_req_valid", 128'(ov),   128'(1));
      chk("bp_req_hold",  128'(ob),   128'(cap));
      chk("bp_no_ready",  128'(rdy1 | rdy0), 128'(0));
      advance();
    end
    v0 = 1'b0; v1 = 1'b0; o_rdy = 1'b1;
    settle();
    advance();
    o_rdy = 1'b0; o_rv = 1'b1; rr1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      o_rsp = rnd_resp();
      settle();
      chk("bp_orr_low",  128'(orr),  128'(0));
      chk("bp_busy",     128'(busy), 128'(1));
      chk("bp_rv1",      128'(rv1),  128'(1));
      chk("bp_rdata1",   128'(d1),   128'(o_rsp.rdata));
      advance();
    end
    rr1 = 1'b1;
    settle();
    chk("bp_release", 128'(orr), 128'(1));
    advance();
    o_rv = 1'b0; rr1 = 1'b0;
    settle();
    chk("bp_idle", 128'(busy), 128'(0));
    advance();

    // Reset while in RESP with a response on offer.
    r0 = rnd_req(); v0 = 1'b1;
    settle();
    advance();
    v0 = 1'b0; o_rdy = 1'b1;
    settle();
    advance();
    o_rdy = 1'b0;
    settle();
    chk("mid_in_resp", 128'(busy), 128'(1));
    advance();
    o_rv = 1'b1; rr0 = 1'b1; o_rsp = rnd_resp(); rst = 1'b1;
    settle();
    chk("mid_rv0_rst", 128'(rv0), 128'(0));
    chk("mid_orr_rst", 128'(orr), 128'(0));
    advance();
    rst = 1'b0;
    settle();
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_rv0",  128'(rv0),  128'(0));
    chk("mid_orr",  128'(orr),  128'(0));
    chk("mid_ov",   128'(ov),   128'(0));
    advance();

    // Stray responses while idle.
    for (int i = 0; i < 3; i++) begin
      o_rv = 1'($urandom); o_rsp = rnd_resp(); rr0 = 1'($urandom); rr1 = 1'($urandom);
      settle();
      chk("stray_rv", 128'({rv1, rv0}), 128'(0));
      chk("stray_orr", 128'(orr), 128'(0));
      chk("stray_busy", 128'(busy), 128'(0));
      advance();
    end

    // Random traffic with occasional reset.
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst   = ($urandom_range(0, 63) == 0);
      v0    = ($urandom_range(0, 9) < 6);
      v1    = ($urandom_range(0, 9) < 6);
      r0    = rnd_req();
      r1    = rnd_req();
      rr0   = ($urandom_range(0, 9) < 7);
      rr1   = ($urandom_range(0, 9) < 7);
      o_rdy = ($urandom_range(0, 1) == 1);
      o_rv  = ($urandom_range(0, 9) < 4);
      o_rsp = rnd_resp();
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
